// File: rtl/eth_pkg.sv
// Shared constants, FSM state type and helper functions for the GMII transmit framer.
package eth_pkg;

  localparam logic [7:0]  GMII_PREAMBLE   = 8'h55;
  localparam logic [7:0]  GMII_SFD        = 8'hD5;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

  // Framer states; ST_PAD is skipped when the frame already meets the minimum size.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_SFD  = 3'd2,
    ST_DATA = 3'd3,
    ST_PAD  = 3'd4,
    ST_FCS  = 3'd5,
    ST_IFG  = 3'd6
  } tx_state_t;

  // Number of valid bytes in the final word: 00 means a full word.
  function automatic logic [2:0] be_to_len(input logic [1:0] be);
    return (be == 2'b00) ? 3'd4 : {1'b0, be};
  endfunction

  // One byte of the reflected CRC-32, data bit 0 first; no final inversion.
  function automatic logic [31:0] crc32_update(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h000000, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Byte-wide Ethernet CRC-32 accumulator: one registered update per enabled byte.
// The register holds the raw running value; the transmitter inverts it for the FCS.
module eth_crc32_d8
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  d,
  output logic [31:0] crc
);

  logic [31:0] crc_reg;

  // Re-seed on init (takes priority), otherwise fold in one byte when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_reg <= CRC32_INIT;
    end else if (init) begin
      crc_reg <= CRC32_INIT;
    end else if (en) begin
      crc_reg <= crc32_update(crc_reg, d);
    end
  end

  assign crc = crc_reg;

endmodule

// File: rtl/eth_gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD, word-to-byte serialisation, minimum-size padding,
// FCS append and inter-frame gap. All GMII outputs are registered; in_rd is combinational.
module eth_gmii_tx_framer
  import eth_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_FRAME    = 60,
  parameter int IFG_BYTES    = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_data,
  input  logic [1:0]  in_be,
  input  logic        in_rdy,
  input  logic        in_sop,
  input  logic        in_eop,
  output logic        in_rd,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun
);

  // The IDLE cycle that accepts a frame already emits the first preamble byte,
  // so PRE covers the remaining PREAMBLE_LEN-1 bytes.
  localparam logic [7:0]  PRE_LAST   = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0]  IFG_LAST   = 8'(IFG_BYTES - 1);
  localparam logic [15:0] MIN_W      = 16'(MIN_FRAME);
  localparam tx_state_t   PRE_ENTRY  = (PREAMBLE_LEN > 1) ? ST_PRE : ST_SFD;

  tx_state_t   state;
  logic [7:0]  pre_cnt;
  logic [31:0] shift_reg;
  logic [2:0]  bytes_left;
  logic        eop_reg;
  logic [15:0] byte_cnt;
  logic [1:0]  fcs_idx;
  logic [7:0]  ifg_cnt;

  logic [31:0] crc;
  logic        crc_init;
  logic        crc_en;
  logic [7:0]  crc_d;

  logic        last_byte;
  logic        need_word;
  logic [15:0] cnt_inc;
  logic [2:0]  load_len;
  logic [7:0]  fcs_byte;

  // Word-boundary decisions and the pop strobe, derived from the current state.
  always_comb begin
    last_byte = (bytes_left == 3'd1);
    need_word = (state == ST_SFD) || ((state == ST_DATA) && last_byte && !eop_reg);
    in_rd     = need_word && in_rdy;
    cnt_inc   = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
    load_len  = in_eop ? be_to_len(in_be) : 3'd4;
  end

  // FCS goes out as the inverted CRC, least significant byte first.
  always_comb begin
    fcs_byte = ~crc[7:0];
    case (fcs_idx)
      2'd0: fcs_byte = ~crc[7:0];
      2'd1: fcs_byte = ~crc[15:8];
      2'd2: fcs_byte = ~crc[23:16];
      2'd3: fcs_byte = ~crc[31:24];
      default: fcs_byte = ~crc[7:0];
    endcase
  end

  // CRC covers exactly the bytes sent in DATA and PAD; it restarts during SFD.
  always_comb begin
    crc_init = (state == ST_SFD);
    crc_en   = (state == ST_DATA) || (state == ST_PAD);
    crc_d    = (state == ST_DATA) ? shift_reg[31:24] : 8'h00;
  end

  eth_crc32_d8 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (crc_init),
    .en    (crc_en),
    .d     (crc_d),
    .crc   (crc)
  );

  // Framer FSM: each state registers the GMII byte it owns, so outputs trail state by one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pre_cnt    <= '0;
      shift_reg  <= '0;
      bytes_left <= '0;
      eop_reg    <= 1'b0;
      byte_cnt   <= '0;
      fcs_idx    <= '0;
      ifg_cnt    <= '0;
      gmii_txd   <= '0;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      gmii_tx_er <= 1'b0;
      case (state)
        ST_IDLE: begin
          gmii_txd   <= 8'h00;
          gmii_tx_en <= 1'b0;
          if (in_rdy && in_sop) begin
            gmii_txd   <= GMII_PREAMBLE;
            gmii_tx_en <= 1'b1;
            pre_cnt    <= 8'd1;
            state      <= PRE_ENTRY;
          end
        end

        ST_PRE: begin
          gmii_txd   <= GMII_PREAMBLE;
          gmii_tx_en <= 1'b1;
          pre_cnt    <= pre_cnt + 8'd1;
          if (pre_cnt == PRE_LAST) begin
            state <= ST_SFD;
          end
        end

        ST_SFD: begin
          byte_cnt   <= '0;
          gmii_tx_en <= 1'b1;
          if (in_rdy) begin
            gmii_txd   <= GMII_SFD;
            shift_reg  <= in_data;
            bytes_left <= load_len;
            eop_reg    <= in_eop;
            state      <= ST_DATA;
          end else begin
            // No first word: flag the frame as errored rather than send an empty body.
            gmii_txd   <= 8'h00;
            gmii_tx_er <= 1'b1;
            underrun   <= 1'b1;
            ifg_cnt    <= '0;
            state      <= ST_IFG;
          end
        end

        ST_DATA: begin
          gmii_txd   <= shift_reg[31:24];
          gmii_tx_en <= 1'b1;
          byte_cnt   <= cnt_inc;
          if (!last_byte) begin
            shift_reg  <= {shift_reg[23:0], 8'h00};
            bytes_left <= bytes_left - 3'd1;
          end else if (eop_reg) begin
            if (cnt_inc < MIN_W) begin
              state <= ST_PAD;
            end else begin
              fcs_idx <= '0;
              state   <= ST_FCS;
            end
          end else if (in_rdy) begin
            // Next word arrives under the last byte of this one: no bubble on the wire.
            shift_reg  <= in_data;
            bytes_left <= load_len;
            eop_reg    <= in_eop;
          end else begin
            // Starved mid-frame: mark this byte errored and abandon the frame without FCS.
            gmii_tx_er <= 1'b1;
            underrun   <= 1'b1;
            ifg_cnt    <= '0;
            state      <= ST_IFG;
          end
        end

        ST_PAD: begin
          gmii_txd   <= 8'h00;
          gmii_tx_en <= 1'b1;
          byte_cnt   <= cnt_inc;
          if (cnt_inc >= MIN_W) begin
            fcs_idx <= '0;
            state   <= ST_FCS;
          end
        end

        ST_FCS: begin
          gmii_txd   <= fcs_byte;
          gmii_tx_en <= 1'b1;
          fcs_idx    <= fcs_idx + 2'd1;
          if (fcs_idx == 2'd3) begin
            ifg_cnt <= '0;
            state   <= ST_IFG;
          end
        end

        ST_IFG: begin
          gmii_txd   <= 8'h00;
          gmii_tx_en <= 1'b0;
          ifg_cnt    <= ifg_cnt + 8'd1;
          if (ifg_cnt == IFG_LAST) begin
            frame_done <= 1'b1;
            state      <= ST_IDLE;
          end
        end

        default: begin
          gmii_txd   <= 8'h00;
          gmii_tx_en <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule
